// File: rtl/lamp_speed_ctrl.sv
// -----------------------------------------------------------------------------
// lamp_speed_ctrl
//
// Front-panel speed controller for the colour-lamp chaser. Two raw pushbuttons
// (faster / slower) are synchronised and debounced. Each accepted press moves
// a saturating 4-bit speed level one step. The new level is presented on
// data_in together with a one-cycle load strobe. Both outputs feed the reload
// value and load input of the chaser's frequency-divider counter directly.
//
// Parameters:
//   DB_CYC  - stable synchronised cycles needed to accept a press or a release
//             (1..65535)
//   REP_CYC - hold cycles between auto-repeat steps (1..65535). Used only when
//             the auto-repeat build option is enabled.
//   MAX_LVL - upper saturation limit of the level (0..15)
//
// Ports:
//   clk     - in  1 : single clock, rising edge
//   reset   - in  1 : asynchronous, active-high; clears all state
//   key_up  - in  1 : raw "faster" button, active-high, may bounce
//   key_dn  - in  1 : raw "slower" button, active-high, may bounce
//   load    - out 1 : registered one-cycle strobe; data_in holds a new level
//   data_in - out 4 : registered speed level (divider reload value)
//   sat     - out 1 : registered; high while data_in == MAX_LVL or data_in == 0
//
// Build option:
//   LAMP_SPEED_AUTO_REPEAT_EN - when defined, holding a key after its first
//   step produces a further step every REP_CYC+1 cycles. When undefined, the
//   repeat counter is absent and HOLD exits only through an accepted release.
// -----------------------------------------------------------------------------
module lamp_speed_ctrl #(
  parameter int DB_CYC  = 16,
  parameter int REP_CYC = 64,
  parameter int MAX_LVL = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_up,
  input  logic       key_dn,
  output logic       load,
  output logic [3:0] data_in,
  output logic       sat
);

  // Elaboration-time guards on the parameter ranges.
  if (DB_CYC < 1 || DB_CYC > 65535) begin : g_bad_db_cyc
    $error("lamp_speed_ctrl: DB_CYC must be in 1..65535");
  end
  if (REP_CYC < 1 || REP_CYC > 65535) begin : g_bad_rep_cyc
    $error("lamp_speed_ctrl: REP_CYC must be in 1..65535");
  end
  if (MAX_LVL < 0 || MAX_LVL > 15) begin : g_bad_max_lvl
    $error("lamp_speed_ctrl: MAX_LVL must be in 0..15");
  end

  localparam logic [15:0] DB_LAST = 16'(DB_CYC - 1);
  localparam logic [3:0]  MAX_L   = 4'(MAX_LVL);

  typedef enum logic [1:0] {
    IDLE,
    DEB,
    STEP,
    HOLD
  } state_t;

  state_t      state;
  logic        ku_meta;
  logic        ku;
  logic        kd_meta;
  logic        kd;
  logic        dir;        // 1 = up (faster), 0 = down (slower)
  logic [15:0] cnt;        // press debounce counter in DEB, release counter in HOLD

`ifdef LAMP_SPEED_AUTO_REPEAT_EN
  localparam logic [15:0] REP_LAST = 16'(REP_CYC - 1);
  logic [15:0] rep_cnt;
`endif

  logic       press_up;
  logic       press_dn;
  logic       press_dir;
  logic       released;
  logic [3:0] lvl_next;

  // Two-flop synchronisers; the raw keys are asynchronous to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ku_meta <= 1'b0;
      ku      <= 1'b0;
      kd_meta <= 1'b0;
      kd      <= 1'b0;
    end else begin
      ku_meta <= key_up;
      ku      <= ku_meta;
      kd_meta <= key_dn;
      kd      <= kd_meta;
    end
  end

  // Key conditions. Both keys high is never a press, so a simultaneous press
  // aborts a debounce and also keeps HOLD from seeing a release.
  always_comb begin
    press_up  = ku & ~kd;
    press_dn  = kd & ~ku;
    press_dir = dir ? press_up : press_dn;
    released  = ~ku & ~kd;
  end

  // Saturating next level; no wrap between 0 and 15 in either direction.
  always_comb begin
    lvl_next = data_in;
    if (dir) begin
      if (data_in < MAX_L) begin
        lvl_next = data_in + 4'd1;
      end
    end else begin
      if (data_in != 4'd0) begin
        lvl_next = data_in - 4'd1;
      end
    end
  end

  // Control FSM with registered outputs. load defaults low every cycle and is
  // raised only on the STEP exit edge when the level actually moved.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      dir     <= 1'b0;
      cnt     <= '0;
`ifdef LAMP_SPEED_AUTO_REPEAT_EN
      rep_cnt <= '0;
`endif
      load    <= 1'b0;
      data_in <= 4'd0;
      sat     <= 1'b1;
    end else begin
      load <= 1'b0;
      case (state)
        IDLE: begin
          if (press_up || press_dn) begin
            dir   <= press_up;
            cnt   <= '0;
            state <= DEB;
          end
        end

        DEB: begin
          if (press_dir) begin
            if (cnt == DB_LAST) begin
              state <= STEP;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end else begin
            state <= IDLE;
          end
        end

        STEP: begin
          data_in <= lvl_next;
          sat     <= (lvl_next == MAX_L) || (lvl_next == 4'd0);
          load    <= (lvl_next != data_in);
          cnt     <= '0;
`ifdef LAMP_SPEED_AUTO_REPEAT_EN
          rep_cnt <= '0;
`endif
          state   <= HOLD;
        end

        HOLD: begin
          // Release needs DB_CYC consecutive cycles with both keys low.
          if (released) begin
            if (cnt == DB_LAST) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end else begin
            cnt <= '0;
          end
`ifdef LAMP_SPEED_AUTO_REPEAT_EN
          // Released and pressed-in-dir are mutually exclusive, so at most
          // one of the two exits can fire in a given cycle.
          if (press_dir) begin
            if (rep_cnt == REP_LAST) begin
              rep_cnt <= '0;
              state   <= STEP;
            end else begin
              rep_cnt <= rep_cnt + 16'd1;
            end
          end else begin
            rep_cnt <= '0;
          end
`endif
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
